// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared types and constants for the MAC transmit framer.
//   tx_state_t    : framer FSM state encoding
//   PREAMBLE_BYTE : preamble octet (0x55)
//   SFD_BYTE      : start-of-frame delimiter (0xD5)
//   CRC_POLY      : reflected IEEE 802.3 CRC-32 polynomial
//   CRC_INIT      : CRC-32 seed
// ---------------------------------------------------------------------------
package mac_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      SFD,
      PAYLOAD,
      PAD,
      FCS,
      DRAIN,
      IFG
   } tx_state_t;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

endpackage

// File: rtl/crc32_byte.sv
// ---------------------------------------------------------------------------
// crc32_byte
// Combinational one-byte step of the reflected IEEE 802.3 CRC-32.
// Data bits are consumed LSB first. No state; the caller owns the register.
//   crc_in  [31:0] : running CRC before this byte
//   data    [7:0]  : byte to fold in
//   crc_out [31:0] : running CRC after this byte
// ---------------------------------------------------------------------------
module crc32_byte
   import mac_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   logic [31:0] c;

   always_comb begin
      c = crc_in ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      crc_out = c;
   end

endmodule

// File: rtl/mac_tx_framer.sv
// ---------------------------------------------------------------------------
// mac_tx_framer
// Turns a byte-wide packet stream into a GMII transmit stream:
// preamble, SFD, payload, zero pad up to MIN_FRAME_BYTES, CRC-32 FCS and
// an enforced inter-frame gap. All tx_* outputs are registered.
//   mac_clk         : byte clock
//   rst             : asynchronous active-high reset
//   s_startofpacket : first beat of packet
//   s_endofpacket   : last beat of packet
//   s_valid         : beat valid
//   s_data  [7:0]   : payload byte
//   s_error         : beat corrupt, forwarded as tx_er
//   s_ready         : beat accepted this cycle (combinational)
//   tx_en           : GMII transmit enable
//   tx_data [7:0]   : GMII transmit data
//   tx_er           : GMII transmit error
//   busy            : FSM not in IDLE
// ---------------------------------------------------------------------------
module mac_tx_framer
   import mac_pkg::*;
#(
   parameter int PREAMBLE_BYTES  = 7,
   parameter int MIN_FRAME_BYTES = 60,
   parameter int IFG_BYTES       = 12
) (
   input  logic       mac_clk,
   input  logic       rst,
   input  logic       s_startofpacket,
   input  logic       s_endofpacket,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   input  logic       s_error,
   output logic       s_ready,
   output logic       tx_en,
   output logic [7:0] tx_data,
   output logic       tx_er,
   output logic       busy
);

   localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES - 1);
   localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
   localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME_BYTES);

   tx_state_t   state_q, state_d;
   logic [31:0] crc_q, crc_d, crc_next, fcs;
   logic [15:0] byte_cnt_q, byte_cnt_d, byte_cnt_inc;
   logic [7:0]  cnt_q, cnt_d;
   logic        tx_en_q, tx_en_d;
   logic        tx_er_q, tx_er_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic [7:0]  crc_data;

   assign byte_cnt_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
   assign crc_data     = (state_q == PAD) ? 8'h00 : s_data;
   assign fcs          = ~crc_q;

   crc32_byte u_crc (
      .crc_in  (crc_q),
      .data    (crc_data),
      .crc_out (crc_next)
   );

   always_comb begin
      state_d    = state_q;
      crc_d      = crc_q;
      byte_cnt_d = byte_cnt_q;
      cnt_d      = cnt_q;
      tx_en_d    = 1'b0;
      tx_er_d    = 1'b0;
      tx_data_d  = 8'h00;
      s_ready    = 1'b0;

      case (state_q)
         IDLE: begin
            if (s_valid) begin
               if (s_startofpacket) begin
                  // The SOP cycle already decides the first preamble byte, so
                  // tx_en rises the cycle after SOP is seen and back-to-back
                  // frames are separated by exactly IFG_BYTES idle cycles.
                  tx_en_d   = 1'b1;
                  tx_data_d = PREAMBLE_BYTE;
                  cnt_d     = 8'd1;
                  state_d   = (PREAMBLE_BYTES > 1) ? PREAMBLE : SFD;
               end else begin
                  s_ready = 1'b1;   // orphan beat, dropped
               end
            end
         end

         PREAMBLE: begin
            tx_en_d   = 1'b1;
            tx_data_d = PREAMBLE_BYTE;
            cnt_d     = cnt_q + 8'd1;
            if (cnt_q == PRE_LAST) begin
               cnt_d   = 8'd0;
               state_d = SFD;
            end
         end

         SFD: begin
            tx_en_d    = 1'b1;
            tx_data_d  = SFD_BYTE;
            byte_cnt_d = 16'd0;
            state_d    = PAYLOAD;
         end

         PAYLOAD: begin
            s_ready = 1'b1;
            tx_en_d = 1'b1;
            if (s_valid) begin
               tx_data_d  = s_data;
               tx_er_d    = s_error;
               crc_d      = crc_next;
               byte_cnt_d = byte_cnt_inc;
               if (s_endofpacket) begin
                  cnt_d   = 8'd0;
                  state_d = (byte_cnt_inc < MIN_LEN) ? PAD : FCS;
               end
            end else begin
               // Underrun: poison the frame with one error byte. An eop always
               // leaves PAYLOAD, so the rest of the packet is still upstream
               // and has to be drained.
               tx_er_d = 1'b1;
               state_d = DRAIN;
            end
         end

         PAD: begin
            tx_en_d    = 1'b1;
            crc_d      = crc_next;
            byte_cnt_d = byte_cnt_inc;
            if (byte_cnt_inc >= MIN_LEN) begin
               cnt_d   = 8'd0;
               state_d = FCS;
            end
         end

         FCS: begin
            tx_en_d   = 1'b1;
            tx_data_d = fcs[{cnt_q[1:0], 3'b000} +: 8];
            cnt_d     = cnt_q + 8'd1;
            if (cnt_q == 8'd3) begin
               cnt_d   = 8'd0;
               state_d = IFG;
            end
         end

         DRAIN: begin
            s_ready = 1'b1;
            if (s_valid && s_endofpacket) begin
               cnt_d   = 8'd0;
               state_d = IFG;
            end
         end

         IFG: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == IFG_LAST) begin
               cnt_d   = 8'd0;
               crc_d   = CRC_INIT;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge mac_clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         crc_q      <= CRC_INIT;
         byte_cnt_q <= 16'd0;
         cnt_q      <= 8'd0;
         tx_en_q    <= 1'b0;
         tx_er_q    <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         crc_q      <= crc_d;
         byte_cnt_q <= byte_cnt_d;
         cnt_q      <= cnt_d;
         tx_en_q    <= tx_en_d;
         tx_er_q    <= tx_er_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign tx_en   = tx_en_q;
   assign tx_er   = tx_er_q;
   assign tx_data = tx_data_q;
   assign busy    = (state_q != IDLE);

endmodule
